e203_ifu_brpred: RTL and testbench
==================================

Name: e203_ifu_brpred

Overview:
- Static branch predictor in the IFU that consumes the mini-decoder's branch/jump classification and computes the predicted next-PC adder operands.
- Resolves JALR base-register reads:
  - x0 is handled as a constant.
  - x1 is read from a dedicated forwarded copy.
  - xN (N≥2) is read through a handshake on shared regfile read port 1, sequenced by a small FSM.
- Stalls fetch (bpu_wait) while a JALR base is unavailable.

Parameters:
- PC_SIZE, 32, width of PC and adder operands.
- XLEN, 32, register data width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  PC_SIZE  PC of the decoded instruction.
- dec_i_valid  in  1  decoded instruction valid.
- dec_i_ready  in  1  IFU accepts the decoded instruction this cycle.
- dec_jal  in  1  instruction is JAL.
- dec_jalr  in  1  instruction is JALR.
- dec_bxx  in  1  instruction is a conditional branch.
- dec_bjp_imm  in  32  sign-extended branch/jump immediate.
- dec_jalr_rs1idx  in  5  JALR base register index.
- oitf_empty  in  1  no long-pipe instruction outstanding.
- ir_valid  in  1  IR stage holds a valid instruction.
- ir_rs1en  in  1  IR instruction uses read port 1 this cycle.
- ir_rd_wen  in  1  IR instruction writes rd.
- ir_rd_idx  in  5  IR instruction rd index.
- rf2bpu_x1  in  XLEN  live x1 value.
- rf2bpu_rs1  in  XLEN  read port 1 data, valid the cycle after the request.
- flush_req  in  1  pipeline flush.
- bpu2rf_rs1_ena  out  1  read port 1 request (combinational).
- bpu_wait  out  1  stall fetch this cycle.
- prdt_taken  out  1  predicted taken.
- prdt_pc_add_op1  out  PC_SIZE  adder operand 1.
- prdt_pc_add_op2  out  PC_SIZE  adder operand 2.

Behaviour:
- FSM states: IDLE, REQ, RDY.
  - Encoding is registered.
  - Reset state is IDLE.
  - rs1_q (XLEN) resets to 0.
- Qualified decode bits:
  - jal_v = dec_i_valid & dec_jal
  - jalr_v = dec_i_valid & dec_jalr
  - bxx_v = dec_i_valid & dec_bxx
- Index classes: is_x0 = (rs1idx==0); is_x1 = (rs1idx==1); is_xn = otherwise.
- Dependency terms:
  - dep_x1 = ~oitf_empty | (ir_valid & ir_rd_wen & ir_rd_idx==1)
  - dep_xn = ~oitf_empty | (ir_valid & ir_rd_wen & ir_rd_idx==dec_jalr_rs1idx)
  - port_busy = ir_valid & ir_rs1en
- prdt_taken = jal_v | jalr_v | (bxx_v & dec_bjp_imm[31]). Backward branches are predicted taken, forward branches not taken.
- prdt_pc_add_op2 = dec_bjp_imm.
- prdt_pc_add_op1 selection:
  - bxx or jal: pc.
  - jalr, x0: 0.
  - jalr, x1: rf2bpu_x1.
  - jalr, xN: rf2bpu_rs1 in REQ; rs1_q in RDY.
  - Otherwise: pc.
- bpu2rf_rs1_ena = (state==IDLE) & jalr_v & is_xn & ~dep_xn & ~port_busy & ~flush_req.
- FSM transitions:
  - IDLE→REQ when bpu2rf_rs1_ena is asserted.
  - REQ: capture rs1_q<=rf2bpu_rs1. Go to IDLE if dec_i_ready | flush_req, else go to RDY.
  - RDY: hold rs1_q. Go to IDLE on dec_i_ready | flush_req.
- bpu_wait, asserted only when jalr_v:
  - x0: 0.
  - x1: dep_x1.
  - xN: (state==IDLE).
  - Not JALR: 0.
- Latency:
  - An xN JALR stalls at least 1 cycle: the request cycle.
  - Operands are valid in the cycle after the request.
- Flush has priority over all FSM transitions. A flush in REQ or RDY returns to IDLE; rs1_q is not cleared.
- Reset asserted mid-operation: state goes to IDLE and rs1_q to 0 immediately (asynchronous).
- With all inputs 0 after reset, all outputs are 0.

Test Plan:
1. JAL: pc=0x80000100, imm=0x20, dec_jal=1, valid=1 -> taken=1, op1=0x80000100, op2=0x20, wait=0, ena=0.
2. BXX direction:
   - imm=0xFFFFFFF0 -> taken=1, op1=pc.
   - imm=0x10 -> taken=0.
3. JALR x1:
   - oitf_empty=0 -> wait=1.
   - Then oitf_empty=1, x1=0x1234 -> wait=0, op1=0x1234.
4. JALR x5, port free:
   - Cycle N: ena=1, wait=1.
   - Cycle N+1: rf2bpu_rs1=0xABCD0000 -> op1=0xABCD0000, wait=0.
   - dec_i_ready=0 -> RDY holds op1 while rf2bpu_rs1 changes.
   - dec_i_ready=1 -> IDLE.
5. JALR x7 stall cases:
   - ir_valid=1, ir_rs1en=1 -> ena=0, wait=1 until ir_rs1en drops.
   - ir_rd_wen=1, ir_rd_idx=7 -> ena=0 until that dependency clears.
6. Flush and reset:
   - flush_req in REQ -> next state IDLE, ena=0 while flush is held.
   - rst_n low in RDY -> IDLE immediately, op1 for a pending xN JALR = rf2bpu_rs1 path not used, wait=1.

Source files
------------

// File: rtl/e203_ifu_brpred.sv
// Static branch predictor for the IFU: predicts direction and supplies next-PC adder operands,
// fetching JALR base registers from x0, the forwarded x1 copy, or regfile read port 1.
module e203_ifu_brpred #(
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_SIZE-1:0] pc,
    input  logic               dec_i_valid,
    input  logic               dec_i_ready,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [31:0]        dec_bjp_imm,
    input  logic [4:0]         dec_jalr_rs1idx,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rs1en,
    input  logic               ir_rd_wen,
    input  logic [4:0]         ir_rd_idx,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    input  logic               flush_req,
    output logic               bpu2rf_rs1_ena,
    output logic               bpu_wait,
    output logic               prdt_taken,
    output logic [PC_SIZE-1:0] prdt_pc_add_op1,
    output logic [PC_SIZE-1:0] prdt_pc_add_op2
);

    typedef enum logic [1:0] {StIdle, StReq, StRdy} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;

    logic jal_v, jalr_v, bxx_v;
    logic is_x0, is_x1, is_xn;
    logic dep_x1, dep_xn, port_busy;
    logic leave_wait;

    always_comb begin
        jal_v     = dec_i_valid & dec_jal;
        jalr_v    = dec_i_valid & dec_jalr;
        bxx_v     = dec_i_valid & dec_bxx;
        is_x0     = (dec_jalr_rs1idx == 5'd0);
        is_x1     = (dec_jalr_rs1idx == 5'd1);
        is_xn     = ~is_x0 & ~is_x1;
        dep_x1    = ~oitf_empty | (ir_valid & ir_rd_wen & (ir_rd_idx == 5'd1));
        dep_xn    = ~oitf_empty | (ir_valid & ir_rd_wen & (ir_rd_idx == dec_jalr_rs1idx));
        port_busy = ir_valid & ir_rs1en;
        leave_wait = dec_i_ready | flush_req;
    end

    always_comb begin
        // Backward conditional branches (negative offset) are predicted taken.
        prdt_taken      = jal_v | jalr_v | (bxx_v & dec_bjp_imm[31]);
        prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
        bpu2rf_rs1_ena  = (state_q == StIdle) & jalr_v & is_xn & ~dep_xn & ~port_busy
                          & ~flush_req;

        prdt_pc_add_op1 = pc;
        bpu_wait        = 1'b0;
        if (jalr_v) begin
            if (is_x0) begin
                prdt_pc_add_op1 = '0;
            end else if (is_x1) begin
                prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
                bpu_wait        = dep_x1;
            end else begin
                // Read data arrives the cycle after the request; afterwards it lives in rs1_q.
                prdt_pc_add_op1 = (state_q == StReq) ? PC_SIZE'(rf2bpu_rs1) : PC_SIZE'(rs1_q);
                bpu_wait        = (state_q == StIdle);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        case (state_q)
            StIdle: begin
                if (bpu2rf_rs1_ena) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                rs1_d   = rf2bpu_rs1;
                state_d = leave_wait ? StIdle : StRdy;
            end
            StRdy: begin
                if (leave_wait) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rs1_q   <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
        end
    end

endmodule

// File: tb/tb_e203_ifu_brpred.sv
// Directed bench for e203_ifu_brpred: a vector table for single-cycle decode cases plus
// hand-written sequences for the JALR xN handshake, flush and asynchronous reset.
module tb_e203_ifu_brpred;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        dec_i_valid, dec_i_ready, dec_jal, dec_jalr, dec_bxx;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx;
    logic        oitf_empty, ir_valid, ir_rs1en, ir_rd_wen;
    logic [4:0]  ir_rd_idx;
    logic [31:0] rf2bpu_x1, rf2bpu_rs1;
    logic        flush_req;
    logic        bpu2rf_rs1_ena, bpu_wait, prdt_taken;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

    int errors = 0;
    int checks = 0;

    e203_ifu_brpred #(.PC_SIZE(32), .XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .dec_i_valid     (dec_i_valid),
        .dec_i_ready     (dec_i_ready),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_bxx         (dec_bxx),
        .dec_bjp_imm     (dec_bjp_imm),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .oitf_empty      (oitf_empty),
        .ir_valid        (ir_valid),
        .ir_rs1en        (ir_rs1en),
        .ir_rd_wen       (ir_rd_wen),
        .ir_rd_idx       (ir_rd_idx),
        .rf2bpu_x1       (rf2bpu_x1),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .flush_req       (flush_req),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu_wait        (bpu_wait),
        .prdt_taken      (prdt_taken),
        .prdt_pc_add_op1 (prdt_pc_add_op1),
        .prdt_pc_add_op2 (prdt_pc_add_op2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid, jal, jalr, bxx;
        logic [31:0] imm;
        logic [4:0]  idx;
        logic        oitf_empty, ir_valid, ir_rs1en, ir_rd_wen;
        logic [4:0]  ir_rd_idx;
        logic [31:0] x1;
        logic        flush;
        logic        e_taken, e_wait, e_ena;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    vec_t vecs[16];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        pc = '0; dec_i_valid = 0; dec_i_ready = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
        dec_bjp_imm = '0; dec_jalr_rs1idx = '0; oitf_empty = 0; ir_valid = 0; ir_rs1en = 0;
        ir_rd_wen = 0; ir_rd_idx = '0; rf2bpu_x1 = '0; rf2bpu_rs1 = '0; flush_req = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic jalr_xn(input logic [4:0] idx);
        dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = idx; oitf_empty = 1;
        pc = 32'h8000_0200; dec_bjp_imm = 32'h4;
    endtask

    initial begin
        //          pc            v  jal jalr bxx imm           idx  oe irv rs1 rdw rdi  x1           fl  tk wt en op1           op2
        vecs[0]  = '{32'h0,       0, 0, 0, 0, 32'h0,        5'd0, 0, 0, 0, 0, 5'd0, 32'h0,       0, 0, 0, 0, 32'h0,       32'h0};
        vecs[1]  = '{32'h80000100,1, 1, 0, 0, 32'h20,       5'd0, 1, 0, 0, 0, 5'd0, 32'h0,       0, 1, 0, 0, 32'h80000100,32'h20};
        vecs[2]  = '{32'h1000,    1, 0, 0, 1, 32'hFFFFFFF0, 5'd0, 1, 0, 0, 0, 5'd0, 32'h0,       0, 1, 0, 0, 32'h1000,    32'hFFFFFFF0};
        vecs[3]  = '{32'h1000,    1, 0, 0, 1, 32'h10,       5'd0, 1, 0, 0, 0, 5'd0, 32'h0,       0, 0, 0, 0, 32'h1000,    32'h10};
        vecs[4]  = '{32'h2000,    0, 0, 0, 1, 32'hFFFFFFF0, 5'd0, 1, 0, 0, 0, 5'd0, 32'h0,       0, 0, 0, 0, 32'h2000,    32'hFFFFFFF0};
        vecs[5]  = '{32'h3000,    1, 0, 1, 0, 32'h8,        5'd0, 0, 0, 0, 0, 5'd0, 32'h0,       0, 1, 0, 0, 32'h0,       32'h8};
        vecs[6]  = '{32'h3000,    1, 0, 1, 0, 32'h8,        5'd1, 0, 0, 0, 0, 5'd0, 32'h1234,    0, 1, 1, 0, 32'h1234,    32'h8};
        vecs[7]  = '{32'h3000,    1, 0, 1, 0, 32'h8,        5'd1, 1, 0, 0, 0, 5'd0, 32'h1234,    0, 1, 0, 0, 32'h1234,    32'h8};
        vecs[8]  = '{32'h3000,    1, 0, 1, 0, 32'h8,        5'd1, 1, 1, 0, 1, 5'd1, 32'h55,      0, 1, 1, 0, 32'h55,      32'h8};
        vecs[9]  = '{32'h3000,    1, 0, 1, 0, 32'h8,        5'd1, 1, 0, 0, 1, 5'd1, 32'h55,      0, 1, 0, 0, 32'h55,      32'h8};
        vecs[10] = '{32'h3000,    1, 0, 1, 0, 32'hC,        5'd7, 1, 1, 1, 0, 5'd0, 32'h0,       0, 1, 1, 0, 32'h0,       32'hC};
        vecs[11] = '{32'h3000,    1, 0, 1, 0, 32'hC,        5'd7, 1, 1, 0, 1, 5'd7, 32'h0,       0, 1, 1, 0, 32'h0,       32'hC};
        vecs[12] = '{32'h3000,    1, 0, 1, 0, 32'hC,        5'd7, 1, 1, 0, 1, 5'd6, 32'h0,       0, 1, 1, 1, 32'h0,       32'hC};
        vecs[13] = '{32'h3000,    1, 0, 1, 0, 32'hC,        5'd7, 0, 0, 0, 0, 5'd0, 32'h0,       0, 1, 1, 0, 32'h0,       32'hC};
        vecs[14] = '{32'h3000,    1, 0, 1, 0, 32'hC,        5'd7, 1, 0, 0, 0, 5'd0, 32'h0,       1, 1, 1, 0, 32'h0,       32'hC};
        vecs[15] = '{32'h44,      1, 0, 0, 0, 32'h8,        5'd0, 1, 0, 0, 0, 5'd0, 32'h0,       0, 0, 0, 0, 32'h44,      32'h8};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("reset ena", bpu2rf_rs1_ena, 1'b0);
        chk1("reset wait", bpu_wait, 1'b0);
        chk1("reset taken", prdt_taken, 1'b0);
        chk32("reset op1", prdt_pc_add_op1, 32'h0);
        chk32("reset op2", prdt_pc_add_op2, 32'h0);

        // Table: each vector is applied from IDLE with rs1_q cleared by a reset pulse.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pulse_reset();
            pc = vecs[i].pc; dec_i_valid = vecs[i].valid; dec_jal = vecs[i].jal;
            dec_jalr = vecs[i].jalr; dec_bxx = vecs[i].bxx; dec_bjp_imm = vecs[i].imm;
            dec_jalr_rs1idx = vecs[i].idx; oitf_empty = vecs[i].oitf_empty;
            ir_valid = vecs[i].ir_valid; ir_rs1en = vecs[i].ir_rs1en;
            ir_rd_wen = vecs[i].ir_rd_wen; ir_rd_idx = vecs[i].ir_rd_idx;
            rf2bpu_x1 = vecs[i].x1; flush_req = vecs[i].flush; rf2bpu_rs1 = 32'hDEAD0000;
            #1;
            chk1($sformatf("v%0d taken", i), prdt_taken, vecs[i].e_taken);
            chk1($sformatf("v%0d wait", i), bpu_wait, vecs[i].e_wait);
            chk1($sformatf("v%0d ena", i), bpu2rf_rs1_ena, vecs[i].e_ena);
            chk32($sformatf("v%0d op1", i), prdt_pc_add_op1, vecs[i].e_op1);
            chk32($sformatf("v%0d op2", i), prdt_pc_add_op2, vecs[i].e_op2);
            clear_inputs();
        end

        // JALR x5: request, data next cycle, hold in RDY, release on dec_i_ready.
        @(negedge clk);
        pulse_reset();
        jalr_xn(5'd5);
        rf2bpu_rs1 = 32'hABCD0000;
        #1;
        chk1("x5 req ena", bpu2rf_rs1_ena, 1'b1);
        chk1("x5 req wait", bpu_wait, 1'b1);
        @(negedge clk);
        #1;
        chk1("x5 data ena", bpu2rf_rs1_ena, 1'b0);
        chk1("x5 data wait", bpu_wait, 1'b0);
        chk32("x5 data op1", prdt_pc_add_op1, 32'hABCD0000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rf2bpu_rs1 = 32'h11112222 + c;
            #1;
            chk32($sformatf("x5 rdy%0d op1", c), prdt_pc_add_op1, 32'hABCD0000);
            chk1($sformatf("x5 rdy%0d wait", c), bpu_wait, 1'b0);
            chk1($sformatf("x5 rdy%0d ena", c), bpu2rf_rs1_ena, 1'b0);
        end
        dec_i_ready = 1;
        @(negedge clk);
        dec_i_ready = 0;
        #1;
        chk1("x5 idle ena", bpu2rf_rs1_ena, 1'b1);
        chk1("x5 idle wait", bpu_wait, 1'b1);
        // REQ with dec_i_ready goes straight back to IDLE.
        @(negedge clk);
        dec_i_ready = 1;
        #1;
        chk1("x5 req2 wait", bpu_wait, 1'b0);
        @(negedge clk);
        dec_i_ready = 0;
        #1;
        chk1("x5 req2 idle wait", bpu_wait, 1'b1);
        chk1("x5 req2 idle ena", bpu2rf_rs1_ena, 1'b1);

        // JALR x7 blocked by read-port use, then by an rd dependency.
        @(negedge clk);
        clear_inputs();
        pulse_reset();
        jalr_xn(5'd7);
        ir_valid = 1; ir_rs1en = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk1($sformatf("x7 port%0d ena", c), bpu2rf_rs1_ena, 1'b0);
            chk1($sformatf("x7 port%0d wait", c), bpu_wait, 1'b1);
            @(negedge clk);
        end
        ir_rs1en = 0; ir_rd_wen = 1; ir_rd_idx = 5'd7;
        #1;
        chk1("x7 dep ena", bpu2rf_rs1_ena, 1'b0);
        chk1("x7 dep wait", bpu_wait, 1'b1);
        @(negedge clk);
        ir_rd_wen = 0;
        rf2bpu_rs1 = 32'h0000_7777;
        #1;
        chk1("x7 free ena", bpu2rf_rs1_ena, 1'b1);
        @(negedge clk);
        #1;
        chk1("x7 req wait", bpu_wait, 1'b0);
        chk32("x7 req op1", prdt_pc_add_op1, 32'h0000_7777);

        // Flush while in REQ returns to IDLE; no request while flush is held.
        flush_req = 1;
        #1;
        chk1("flush req ena", bpu2rf_rs1_ena, 1'b0);
        @(negedge clk);
        #1;
        chk1("flush idle ena", bpu2rf_rs1_ena, 1'b0);
        chk1("flush idle wait", bpu_wait, 1'b1);
        flush_req = 0;
        #1;
        chk1("flush release ena", bpu2rf_rs1_ena, 1'b1);

        // Asynchronous reset while in RDY: back to IDLE and rs1_q cleared at once.
        rf2bpu_rs1 = 32'hABCD0000;
        @(negedge clk);
        @(negedge clk);
        rf2bpu_rs1 = 32'h5555AAAA;
        #1;
        chk32("rdy before reset op1", prdt_pc_add_op1, 32'hABCD0000);
        rst_n = 1'b0;
        #1;
        chk1("async reset wait", bpu_wait, 1'b1);
        chk32("async reset op1", prdt_pc_add_op1, 32'h0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
